// File: rtl/nibble_ser_pkg.sv
// Shared types and constants for the nibble serializer.
// The optional parity bit is enabled by defining NIBBLE_SER_PARITY_EN.
package nibble_ser_pkg;

    localparam int NIBBLE_W = 4;
    localparam logic IDLE_LEVEL = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } nser_state_t;

    // Selects the data bit sent at position idx of the frame's data field.
    function automatic logic data_bit(
        input logic [NIBBLE_W-1:0] word,
        input logic [1:0]          idx,
        input logic                msb_first
    );
        logic [1:0] sel;
        sel = msb_first ? (2'(NIBBLE_W - 1) - idx) : idx;
        return word[sel];
    endfunction

endpackage

// File: rtl/nibble_ser_bit_timer.sv
// Bit-period timer: counts 0..BIT_CYCLES-1 and flags the last cycle of each bit.
// Held at zero while restart is high so the first bit of a frame gets a full period.
module nibble_ser_bit_timer #(
    parameter int BIT_CYCLES = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic restart,
    output logic bit_end
);

    localparam int CW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(BIT_CYCLES - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign bit_end = (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (restart || bit_end) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/nibble_serializer.sv
// 4-bit parallel to serial frame transmitter: start, 4 data bits, optional parity, stop.
// Define NIBBLE_SER_PARITY_EN to insert an even-parity bit between data and stop.
module nibble_serializer
    import nibble_ser_pkg::*;
#(
    parameter int BIT_CYCLES = 1,
    parameter bit MSB_FIRST  = 1'b1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    input  logic [NIBBLE_W-1:0] in_data,
    output logic                in_ready,
    output logic                ser_out,
    output logic                busy,
    output logic                frame_done,
    output logic [2:0]          dbg_state
);

    // Handshake: a word transfers on a rising edge where in_valid && in_ready;
    // upstream must hold in_valid/in_data until then, and in_ready depends only on state.

    nser_state_t         state_q, state_d;
    logic [1:0]          idx_q, idx_d;
    logic [NIBBLE_W-1:0] held_q, held_d;
    logic                frame_done_q, frame_done_d;
    logic                bit_end;
    logic                timer_restart;

    assign timer_restart = (state_q == IDLE);

    nibble_ser_bit_timer #(
        .BIT_CYCLES(BIT_CYCLES)
    ) u_timer (
        .clk    (clk),
        .reset  (reset),
        .restart(timer_restart),
        .bit_end(bit_end)
    );

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        held_d       = held_q;
        frame_done_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    held_d  = in_data;
                    idx_d   = 2'd0;
                    state_d = START;
                end
            end
            START: begin
                if (bit_end) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (idx_q == 2'd3) begin
                        idx_d = 2'd0;
`ifdef NIBBLE_SER_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end else begin
                        idx_d = idx_q + 2'd1;
                    end
                end
            end
`ifdef NIBBLE_SER_PARITY_EN
            PARITY: begin
                if (bit_end) begin
                    state_d = STOP;
                end
            end
`endif
            STOP: begin
                if (bit_end) begin
                    state_d      = IDLE;
                    frame_done_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            idx_q        <= 2'd0;
            held_q       <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            held_q       <= held_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Line level is decoded purely from registered state, never from the inputs.
    always_comb begin
        ser_out = IDLE_LEVEL;
        case (state_q)
            START:   ser_out = ~IDLE_LEVEL;
            DATA:    ser_out = data_bit(held_q, idx_q, MSB_FIRST);
`ifdef NIBBLE_SER_PARITY_EN
            PARITY:  ser_out = ^held_q;
`endif
            default: ser_out = IDLE_LEVEL;
        endcase
    end

    assign in_ready   = (state_q == IDLE);
    assign busy       = (state_q != IDLE);
    assign frame_done = frame_done_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_nibble_serializer.sv
// Bench for nibble_serializer: three instances (B=1 MSB-first, B=1 LSB-first, B=3 MSB-first)
// compared against a frame-level reference model; honours NIBBLE_SER_PARITY_EN.
module tb_nibble_serializer;

    import nibble_ser_pkg::*;

`ifdef NIBBLE_SER_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif

    logic       clk;
    logic       reset;
    logic       in_valid   [3];
    logic [3:0] in_data    [3];
    logic       in_ready   [3];
    logic       ser_out    [3];
    logic       busy       [3];
    logic       frame_done [3];
    logic [2:0] dbg_state  [3];

    int total = 0;
    int bad   = 0;
    logic [0:0] exp_q[$];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        nibble_serializer #(
            .BIT_CYCLES(g == 2 ? 3 : 1),
            .MSB_FIRST (g == 1 ? 1'b0 : 1'b1)
        ) u_dut (
            .clk       (clk),
            .reset     (reset),
            .in_valid  (in_valid[g]),
            .in_data   (in_data[g]),
            .in_ready  (in_ready[g]),
            .ser_out   (ser_out[g]),
            .busy      (busy[g]),
            .frame_done(frame_done[g]),
            .dbg_state (dbg_state[g])
        );
    end

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int b_of(input int u);
        return (u == 2) ? 3 : 1;
    endfunction

    function automatic bit msb_of(input int u);
        return (u == 1) ? 1'b0 : 1'b1;
    endfunction

    // Reference model: the line level for every cycle of one frame.
    task automatic build_exp(input logic [3:0] w, input int b, input bit msb);
        exp_q.delete();
        for (int k = 0; k < b; k++) exp_q.push_back(1'b0);
        for (int j = 0; j < 4; j++) begin
            logic bv;
            bv = msb ? w[3 - j] : w[j];
            for (int k = 0; k < b; k++) exp_q.push_back(bv);
        end
        if (PAR != 0) begin
            for (int k = 0; k < b; k++) exp_q.push_back(^w);
        end
        for (int k = 0; k < b; k++) exp_q.push_back(1'b1);
    endtask

    task automatic test_reset;
        reset = 1'b1;
        for (int u = 0; u < 3; u++) begin
            in_valid[u] = 1'b0;
            in_data[u]  = 4'($urandom_range(0, 15));
        end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        for (int u = 0; u < 3; u++) begin
            total++;
            if (in_ready[u] !== 1'b1) begin
                bad++;
                $display("FAIL reset_in_ready u=%0d got=%b exp=1", u, in_ready[u]);
            end
            total++;
            if (ser_out[u] !== 1'b1) begin
                bad++;
                $display("FAIL reset_ser_out u=%0d got=%b exp=1", u, ser_out[u]);
            end
            total++;
            if (busy[u] !== 1'b0) begin
                bad++;
                $display("FAIL reset_busy u=%0d got=%b exp=0", u, busy[u]);
            end
            total++;
            if (frame_done[u] !== 1'b0) begin
                bad++;
                $display("FAIL reset_frame_done u=%0d got=%b exp=0", u, frame_done[u]);
            end
            total++;
            if (dbg_state[u] !== 3'(IDLE)) begin
                bad++;
                $display("FAIL reset_state u=%0d got=%0d exp=%0d", u, dbg_state[u], 3'(IDLE));
            end
        end
    endtask

    // One directed word followed by n_rand random words on instance u.
    task automatic test_frames(input int u, input logic [3:0] first_w, input int n_rand,
                               input string name);
        for (int n = 0; n <= n_rand; n++) begin
            logic [3:0] w;
            int busy_cnt;
            w = (n == 0) ? first_w : 4'($urandom_range(0, 15));
            build_exp(w, b_of(u), msb_of(u));
            in_valid[u] = 1'b1;
            in_data[u]  = w;
            @(negedge clk);
            in_valid[u] = 1'b0;
            busy_cnt = 0;
            for (int i = 0; i < exp_q.size(); i++) begin
                in_data[u] = 4'($urandom_range(0, 15));
                total++;
                if (ser_out[u] !== exp_q[i]) begin
                    bad++;
                    $display("FAIL %s_ser_out word=%h cyc=%0d got=%b exp=%b",
                             name, w, i, ser_out[u], exp_q[i]);
                end
                total++;
                if (busy[u] !== 1'b1 || in_ready[u] !== 1'b0 || frame_done[u] !== 1'b0) begin
                    bad++;
                    $display("FAIL %s_flags word=%h cyc=%0d got busy=%b rdy=%b done=%b exp 1/0/0",
                             name, w, i, busy[u], in_ready[u], frame_done[u]);
                end
                if (busy[u] === 1'b1) busy_cnt++;
                @(negedge clk);
            end
            total++;
            if (frame_done[u] !== 1'b1 || in_ready[u] !== 1'b1 || busy[u] !== 1'b0
                || ser_out[u] !== 1'b1) begin
                bad++;
                $display("FAIL %s_done_cycle word=%h got done=%b rdy=%b busy=%b ser=%b exp 1/1/0/1",
                         name, w, frame_done[u], in_ready[u], busy[u], ser_out[u]);
            end
            total++;
            if (busy_cnt != (6 + PAR) * b_of(u)) begin
                bad++;
                $display("FAIL %s_busy_len word=%h got=%0d exp=%0d",
                         name, w, busy_cnt, (6 + PAR) * b_of(u));
            end
            @(negedge clk);
            total++;
            if (frame_done[u] !== 1'b0) begin
                bad++;
                $display("FAIL %s_done_width word=%h got=%b exp=0", name, w, frame_done[u]);
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [3:0] w1, w2;
        w1 = 4'b1101;
        w2 = 4'b0011;
        build_exp(w1, 1, 1'b1);
        in_valid[0] = 1'b1;
        in_data[0]  = w1;
        @(negedge clk);
        for (int i = 0; i < exp_q.size(); i++) begin
            in_data[0] = (i == exp_q.size() - 1) ? w2 : 4'($urandom_range(0, 15));
            total++;
            if (ser_out[0] !== exp_q[i] || in_ready[0] !== 1'b0) begin
                bad++;
                $display("FAIL b2b_first cyc=%0d got ser=%b rdy=%b exp ser=%b rdy=0",
                         i, ser_out[0], in_ready[0], exp_q[i]);
            end
            @(negedge clk);
        end
        total++;
        if (frame_done[0] !== 1'b1 || in_ready[0] !== 1'b1 || ser_out[0] !== 1'b1) begin
            bad++;
            $display("FAIL b2b_gap got done=%b rdy=%b ser=%b exp 1/1/1",
                     frame_done[0], in_ready[0], ser_out[0]);
        end
        @(negedge clk);
        in_valid[0] = 1'b0;
        build_exp(w2, 1, 1'b1);
        for (int i = 0; i < exp_q.size(); i++) begin
            in_data[0] = 4'($urandom_range(0, 15));
            total++;
            if (ser_out[0] !== exp_q[i] || busy[0] !== 1'b1) begin
                bad++;
                $display("FAIL b2b_second cyc=%0d got ser=%b busy=%b exp ser=%b busy=1",
                         i, ser_out[0], busy[0], exp_q[i]);
            end
            @(negedge clk);
        end
        total++;
        if (frame_done[0] !== 1'b1) begin
            bad++;
            $display("FAIL b2b_second_done got=%b exp=1", frame_done[0]);
        end
        @(negedge clk);
    endtask

    task automatic test_abort;
        logic [3:0] w;
        w = 4'($urandom_range(0, 15));
        build_exp(w, 1, 1'b1);
        in_valid[0] = 1'b1;
        in_data[0]  = w;
        @(negedge clk);
        in_valid[0] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            total++;
            if (ser_out[0] !== exp_q[i]) begin
                bad++;
                $display("FAIL abort_pre cyc=%0d got=%b exp=%b", i, ser_out[0], exp_q[i]);
            end
            if (i < 2) @(negedge clk);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        total++;
        if (ser_out[0] !== 1'b1 || in_ready[0] !== 1'b1 || busy[0] !== 1'b0
            || frame_done[0] !== 1'b0) begin
            bad++;
            $display("FAIL abort_after got ser=%b rdy=%b busy=%b done=%b exp 1/1/0/0",
                     ser_out[0], in_ready[0], busy[0], frame_done[0]);
        end
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            total++;
            if (frame_done[0] !== 1'b0 || ser_out[0] !== 1'b1) begin
                bad++;
                $display("FAIL abort_quiet cyc=%0d got done=%b ser=%b exp 0/1",
                         i, frame_done[0], ser_out[0]);
            end
        end
    endtask

    task automatic test_reset_with_valid;
        reset       = 1'b1;
        in_valid[1] = 1'b1;
        in_data[1]  = 4'($urandom_range(0, 15));
        @(negedge clk);
        reset       = 1'b0;
        in_valid[1] = 1'b0;
        for (int i = 0; i < 2; i++) begin
            total++;
            if (busy[1] !== 1'b0 || ser_out[1] !== 1'b1) begin
                bad++;
                $display("FAIL reset_valid cyc=%0d got busy=%b ser=%b exp 0/1",
                         i, busy[1], ser_out[1]);
            end
            @(negedge clk);
        end
    endtask

    initial begin
        reset = 1'b1;
        for (int u = 0; u < 3; u++) begin
            in_valid[u] = 1'b0;
            in_data[u]  = 4'd0;
        end
        test_reset();
        test_frames(0, 4'b1010, 4, "msb");
        test_frames(1, 4'b0111, 4, "lsb");
        test_frames(2, 4'b1101, 2, "stretch");
        test_back_to_back();
        test_abort();
        test_reset_with_valid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/nibble_serializer.md
# nibble_serializer

Downstream of `ShiftRegister_4bit`, this block accepts the register's 4-bit parallel word over a valid/ready handshake and transmits it on a single serial line. Each frame is a start bit, four data bits, an optional parity bit and a stop bit. Every bit is held for a configurable number of clock cycles. It gives the shift-register datapath its single-wire output stage.

## Interface
Clock is `clk`; reset is `reset`, synchronous and active-high. Single clock domain.

- `BIT_CYCLES`, default 1: clock cycles each serial bit is held; legal range ≥1.
- `MSB_FIRST`, default 1: 1 sends data bit 3 first; 0 sends bit 0 first.

- `clk`  in  1  system clock, rising-edge active.
- `reset`  in  1  synchronous, active-high; returns block to IDLE.
- `in_valid`  in  1  upstream word available.
- `in_data`  in  4  upstream parallel word (shift register `data_output`).
- `in_ready`  out  1  block can accept a word this cycle.
- `ser_out`  out  1  serial line; idle level 1.
- `busy`  out  1  frame in progress.
- `frame_done`  out  1  one-cycle pulse after the stop bit completes.

## Operation
- FSM states: IDLE, START, DATA, PARITY (only with macro), STOP.
- IDLE: `in_ready`=1, `ser_out`=1, `busy`=0.
- Accept: a word is accepted on a rising edge with `in_valid && in_ready`.
  - `in_data` is captured into a 4-bit holding register.
  - The FSM moves to START.
  - Later changes to `in_data` are ignored.
- START: `ser_out`=0 for `BIT_CYCLES` cycles.
- DATA: four bits, each held `BIT_CYCLES` cycles, in the order set by `MSB_FIRST`. A 2-bit index counts 0..3.
- STOP: `ser_out`=1 for `BIT_CYCLES` cycles, then the FSM returns to IDLE.
- `busy`=1 in every non-IDLE state. `in_ready`=0 whenever `busy`=1.
- `in_valid` asserted while busy: not accepted; upstream holds the word until `in_ready`.
- The bit timer counts 0..`BIT_CYCLES`-1. Its width is `$clog2(BIT_CYCLES)`, minimum 1. It reloads on every state or bit change.

## Timing
- Reset values: `in_ready`=1, `ser_out`=1, `busy`=0, `frame_done`=0; state IDLE; counters 0.
- All outputs are registered or decoded from registered state only. No combinational path from `in_valid` or `in_data` to any output.
- Latency (word accepted at edge k, B=`BIT_CYCLES`):
  - Start bit is visible from cycle k+1.
  - Data bits occupy cycles k+1+B .. k+5B.
  - Stop bit occupies cycles k+1+5B .. k+6B (without parity).
- `frame_done`=1 for exactly one cycle, the first IDLE cycle after STOP. `in_ready`=1 in that same cycle.
- Frame length is 6B cycles, or 7B with parity.
- Back-to-back frames: `in_valid` held high gives the next acceptance on the `frame_done` cycle. This leaves a minimum of one idle cycle with `ser_out`=1 between frames.
- Reset mid-frame: the frame is aborted. The next cycle shows reset values, and no `frame_done` is generated.
- Reset together with `in_valid`: reset wins and the word is not accepted.

## Configuration
- Macro: `NIBBLE_SER_PARITY_EN`.
- Defined: a PARITY state is inserted between DATA and STOP. It drives `^held_word` (even parity over the 4 data bits) for B cycles. Frame length becomes 7B.
- Undefined: there is no PARITY state; DATA goes directly to STOP. Frame length is 6B.

## Structure
- Package `nibble_ser_pkg` holds:
  - `localparam NIBBLE_W = 4`
  - `localparam logic IDLE_LEVEL = 1'b1`
  - `typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} nser_state_t`
- Sub-module `nibble_ser_bit_timer`:
  - Parameter: `BIT_CYCLES`.
  - Inputs: `clk`, `reset`, `restart`.
  - Output: `bit_end`, asserted on the last cycle of each bit period.

## Test plan
- Reset behaviour: assert `reset` for 2 cycles → `in_ready`=1, `ser_out`=1, `busy`=0, `frame_done`=0.
- MSB-first frame: B=1, `MSB_FIRST`=1, `in_data`=4'b1010 → `ser_out` 0,1,0,1,0,1 on consecutive cycles, then `frame_done` pulses once.
- LSB-first frame: B=1, `MSB_FIRST`=0, `in_data`=4'b0111 → `ser_out` 0,1,1,1,0,1.
- Stretched bits: B=3, `in_data`=4'b1101 → each level held exactly 3 cycles; `busy` high for 18 cycles.
- Back-to-back: 4'b1101 then 4'b0011 with `in_valid` held → second word accepted on the `frame_done` cycle; exactly one idle cycle between frames; `in_data` changes while busy are ignored.
- Abort and parity: `reset` asserted during the 2nd data bit → next cycle `ser_out`=1, `in_ready`=1, no `frame_done`. With `NIBBLE_SER_PARITY_EN` defined, 4'b1101 → parity bit 1 before stop.
